ysyx_23060061_lsu: RTL and testbench

Load/store unit that sits directly downstream of the decoder/execute path. It takes one memory operation per transaction: MemRW, wmask and memExt from the decoder, and the ALU result as address. It runs a request/response handshake with the data memory, aligns write data and strobes to the word lane, and sign- or zero-extends load data. It then hands a completed result to writeback through a valid/ready handshake.

---
 rtl/ysyx_23060061_lsu.sv | 170 +++++++++++++++++
 tb/tb_ysyx_23060061_lsu.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_lsu.sv
// ysyx_23060061_lsu -- load/store unit between execute and writeback.
//
// Accepts one memory operation at a time from upstream. It forms a word-lane
// request to data memory and waits for a single-cycle response. It then
// presents the extended load data, or zero for stores and no-ops, to writeback.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake (in_ready high only in IDLE)
//   MemRW, wmask, memExt    operation type, byte mask, load extension mode
//   addr, wdata             byte address and right-aligned store data
//   out_valid / out_ready   writeback handshake
//   rdata, err              result and error flag, qualified by out_valid
//   mem_req_*               request channel to data memory (registered)
//   mem_resp_valid/_data    single-cycle read data / write acknowledge
//
// Parameter
//   TIMEOUT                 WAIT cycles without a response before aborting (1..255)
module ysyx_23060061_lsu #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  MemRW,
  input  logic [3:0]  wmask,
  input  logic [2:0]  memExt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;

  stateT       state, nextState;
  logic [7:0]  timeoutCnt;
  logic [2:0]  memExtReg;
  logic [1:0]  byteOff;
  logic        isReadReg;

  logic        misalignedIn;
  logic        timeoutHit;

  // Access-size rules: a half or word access must sit on its natural
  // boundary. A store whose shifted mask spills past byte lane 3 would
  // straddle two words, so it is rejected as well.
  function automatic logic misaligned(input logic [1:0] rw, input logic [3:0] mask,
                                      input logic [2:0] ext, input logic [1:0] off);
    logic       isHalf;
    logic       isWord;
    logic       overflow;
    logic [6:0] wideMask;
    isHalf   = (mask == 4'b0011) || (ext == 3'b010) || (ext == 3'b100);
    // Extension codes above 100 behave like a plain word load.
    isWord   = (mask == 4'b1111) ||
               ((rw == 2'b10) && ((ext == 3'b000) || (ext > 3'b100)));
    wideMask = {3'b000, mask} << off;
    overflow = (rw == 2'b01) && (wideMask[6:4] != 3'b000);
    misaligned = (isHalf && off[0]) || (isWord && (off != 2'b00)) || overflow;
  endfunction

  // Bring the addressed bytes down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                             input logic [1:0] off,
                                             input logic [2:0] ext);
    logic [31:0]        shifted;
    logic signed [7:0]  sByte;
    logic signed [15:0] sHalf;
    shifted = word >> {off, 3'b000};
    sByte   = shifted[7:0];
    sHalf   = shifted[15:0];
    case (ext)
      3'b001:  extendLoad = 32'(sByte);
      3'b010:  extendLoad = 32'(sHalf);
      3'b011:  extendLoad = {24'b0, shifted[7:0]};
      3'b100:  extendLoad = {16'b0, shifted[15:0]};
      default: extendLoad = shifted;
    endcase
  endfunction

  assign misalignedIn = misaligned(MemRW, wmask, memExt, addr[1:0]);
  assign timeoutHit   = (timeoutCnt == TIMEOUT - 8'd1);

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign mem_req_valid = (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (MemRW == 2'b00 || MemRW == 2'b11 || misalignedIn) nextState = DONE;
          else                                                   nextState = REQ;
        end
      end
      REQ:  if (mem_req_ready) nextState = WAIT;
      // A response in the final counted cycle takes priority over the timeout.
      WAIT: if (mem_resp_valid || timeoutHit) nextState = DONE;
      DONE: if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Accept stage: latch the operation and pre-align the request fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeoutCnt    <= 8'd0;
      memExtReg     <= 3'd0;
      byteOff       <= 2'd0;
      isReadReg     <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_wdata <= 32'd0;
      mem_req_wstrb <= 4'd0;
      rdata         <= 32'd0;
      err           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            memExtReg     <= memExt;
            byteOff       <= addr[1:0];
            isReadReg     <= (MemRW == 2'b10);
            mem_req_wen   <= (MemRW == 2'b01);
            mem_req_addr  <= {addr[31:2], 2'b00};
            mem_req_wdata <= wdata << {addr[1:0], 3'b000};
            mem_req_wstrb <= (MemRW == 2'b01) ? (wmask << addr[1:0]) : 4'b0000;
            rdata         <= 32'd0;
            err           <= (MemRW == 2'b11) || ((MemRW != 2'b00) && misalignedIn);
          end
        end
        // Request stage: fields stay put until memory accepts
        REQ: begin
          if (mem_req_ready) timeoutCnt <= 8'd0;
        end
        // Response stage: count cycles, capture and extend the load data
        WAIT: begin
          timeoutCnt <= timeoutCnt + 8'd1;
          if (mem_resp_valid) begin
            rdata <= isReadReg ? extendLoad(mem_resp_data, byteOff, memExtReg) : 32'd0;
            err   <= 1'b0;
          end else if (timeoutHit) begin
            rdata <= 32'd0;
            err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
module tb_ysyx_23060061_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  MemRW;
  logic [3:0]  wmask;
  logic [2:0]  memExt;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int checks   = 0;
  int failures = 0;

  ysyx_23060061_lsu #(.TIMEOUT(8'(TMO))) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .MemRW(MemRW), .wmask(wmask), .memExt(memExt), .addr(addr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .rdata(rdata), .err(err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  rw;
    logic [3:0]  mask;
    logic [2:0]  ext;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] resp;
    int          readyLat;
    int          respLat;   // WAIT-cycle index of the response, 0 = never
    int          outLat;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    bit          expReq;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expStrb;
    logic        expWen;
  } vecT;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    bit          sawReq;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        wen;
    bit          stable;
    bit          busy;
    bit          idleAfter;
    bit          finished;
  } obsT;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // One full transaction with a scripted memory and writeback.
  task automatic runOp(input vecT v, output obsT o);
    int  reqCycles;
    int  waitIdx;
    int  outCnt;
    bit  accepted;
    bit  done;
    o = '{default: 0};
    o.stable = 1'b1;
    o.busy   = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; MemRW = v.rw; wmask = v.mask; memExt = v.ext;
    addr = v.a; wdata = v.wd;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; MemRW = 2'($urandom); wmask = 4'($urandom);
    memExt = 3'($urandom); addr = $urandom; wdata = $urandom;
    reqCycles = 0; waitIdx = 0; outCnt = 0; accepted = 0; done = 0;
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
      if (accepted) begin
        waitIdx++;
        if (waitIdx == v.respLat) begin
          mem_resp_valid = 1'b1; mem_resp_data = v.resp;
        end else begin
          mem_resp_data = $urandom;
        end
      end
      if (in_ready) o.busy = 1'b0;
      if (mem_req_valid) begin
        if (!o.sawReq) begin
          o.addr = mem_req_addr; o.wdata = mem_req_wdata;
          o.strb = mem_req_wstrb; o.wen = mem_req_wen;
        end else if (o.addr !== mem_req_addr || o.wdata !== mem_req_wdata ||
                     o.strb !== mem_req_wstrb || o.wen !== mem_req_wen) begin
          o.stable = 1'b0;
        end
        o.sawReq = 1'b1;
        reqCycles++;
        if (reqCycles > v.readyLat) begin
          mem_req_ready = 1'b1; accepted = 1'b1;
        end
      end
      if (out_valid) begin
        if (outCnt == 0) begin
          o.lat = cyc; o.rdata = rdata; o.err = err;
        end else if (rdata !== o.rdata || err !== o.err) begin
          o.stable = 1'b0;
        end
        outCnt++;
        if (outCnt > v.outLat) begin
          out_ready = 1'b1; done = 1'b1; o.finished = 1'b1;
        end
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
    o.idleAfter = in_ready && !out_valid;
  endtask

  task automatic checkObs(input string tag, input vecT v, input obsT o);
    check({tag, ".finished"}, 32'(o.finished), 32'd1);
    check({tag, ".latency"}, 32'(o.lat), 32'(v.expLat));
    check({tag, ".rdata"}, o.rdata, v.expRdata);
    check({tag, ".err"}, 32'(o.err), 32'(v.expErr));
    check({tag, ".memReqSeen"}, 32'(o.sawReq), 32'(v.expReq));
    check({tag, ".stable"}, 32'(o.stable), 32'd1);
    check({tag, ".inReadyLow"}, 32'(o.busy), 32'd1);
    check({tag, ".idleAfter"}, 32'(o.idleAfter), 32'd1);
    if (v.expReq) begin
      check({tag, ".reqAddr"}, o.addr, v.expAddr);
      check({tag, ".reqWdata"}, o.wdata, v.expWdata);
      check({tag, ".reqWstrb"}, 32'(o.strb), 32'(v.expStrb));
      check({tag, ".reqWen"}, 32'(o.wen), 32'(v.expWen));
    end
  endtask

  // Reference model: expected result derived from the access rules directly.
  task automatic refModel(inout vecT v);
    int unsigned off, val, b, h, span;
    bit isRead, isWrite, half, word, bad;
    off     = v.a % 4;
    isRead  = (v.rw == 2'b10);
    isWrite = (v.rw == 2'b01);
    half = (v.mask == 4'd3) || (v.ext == 3'd2) || (v.ext == 3'd4);
    word = (v.mask == 4'd15) || (isRead && (v.ext == 3'd0 || v.ext >= 3'd5));
    span = int'(v.mask) * (2 ** off);
    bad  = (half && (off % 2 == 1)) || (word && off != 0) || (isWrite && span > 15);
    v.expReq   = (isRead || isWrite) && !bad;
    v.expRdata = 0;
    v.expErr   = (v.rw == 2'b11) || ((isRead || isWrite) && bad);
    v.expLat   = 1;
    v.expAddr  = v.a - off;
    v.expWdata = 32'(v.wd * (2 ** (8 * off)));
    v.expStrb  = isWrite ? 4'(span % 16) : 4'd0;
    v.expWen   = isWrite;
    if (v.expReq) begin
      if (v.respLat >= 1 && v.respLat <= TMO) begin
        v.expLat = v.readyLat + 2 + v.respLat;
        if (isRead) begin
          val = v.resp / (2 ** (8 * off));
          b = val % 256; h = val % 65536;
          case (v.ext)
            3'd1: v.expRdata = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd2: v.expRdata = (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd3: v.expRdata = b;
            3'd4: v.expRdata = h;
            default: v.expRdata = val;
          endcase
        end
      end else begin
        v.expLat = v.readyLat + 2 + TMO;
        v.expErr = 1'b1;
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".rdata"}, rdata, 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
    check({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, ".mem_req_wen"}, 32'(mem_req_wen), 32'd0);
    check({tag, ".mem_req_addr"}, mem_req_addr, 32'd0);
    check({tag, ".mem_req_wdata"}, mem_req_wdata, 32'd0);
    check({tag, ".mem_req_wstrb"}, 32'(mem_req_wstrb), 32'd0);
  endtask

  vecT vecs[19];

  initial begin
    obsT o;
    vecT v;
    int  r;
    vecs[0]  = '{2'b10, 4'b0000, 3'b000, 32'h80000004, 0, 32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF, 0, 3, 1, 32'h80000004, 0, 4'b0000, 0};
    vecs[1]  = '{2'b10, 4'b0000, 3'b001, 32'h80000003, 0, 32'h80FF7F01, 0, 1, 0, 32'hFFFFFF80, 0, 3, 1, 32'h80000000, 0, 4'b0000, 0};
    vecs[2]  = '{2'b10, 4'b0000, 3'b011, 32'h80000003, 0, 32'h80FF7F01, 0, 1, 0, 32'h00000080, 0, 3, 1, 32'h80000000, 0, 4'b0000, 0};
    vecs[3]  = '{2'b10, 4'b0000, 3'b010, 32'h80000002, 0, 32'h80FF7F01, 0, 1, 0, 32'hFFFF80FF, 0, 3, 1, 32'h80000000, 0, 4'b0000, 0};
    vecs[4]  = '{2'b01, 4'b0001, 3'b000, 32'h80000001, 32'h000000AB, 0, 0, 1, 0, 0, 0, 3, 1, 32'h80000000, 32'h0000AB00, 4'b0010, 1};
    vecs[5]  = '{2'b01, 4'b0011, 3'b000, 32'h80000002, 32'h00001234, 0, 0, 1, 0, 0, 0, 3, 1, 32'h80000000, 32'h12340000, 4'b1100, 1};
    vecs[6]  = '{2'b10, 4'b0000, 3'b000, 32'h80000002, 0, 32'h12345678, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 0};
    vecs[7]  = '{2'b11, 4'b1111, 3'b000, 32'h80000000, 0, 32'h12345678, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 0};
    vecs[8]  = '{2'b00, 4'b0000, 3'b000, 32'h80000001, 0, 32'h12345678, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0};
    vecs[9]  = '{2'b10, 4'b0000, 3'b000, 32'h00001000, 0, 32'h11223344, 5, 1, 0, 32'h11223344, 0, 8, 1, 32'h00001000, 0, 4'b0000, 0};
    vecs[10] = '{2'b10, 4'b0000, 3'b001, 32'h00002001, 0, 32'h0000F000, 0, 1, 4, 32'hFFFFFFF0, 0, 3, 1, 32'h00002000, 0, 4'b0000, 0};
    vecs[11] = '{2'b10, 4'b0000, 3'b000, 32'h00003000, 0, 32'h5A5A5A5A, 0, 0, 0, 0, 1, 10, 1, 32'h00003000, 0, 4'b0000, 0};
    vecs[12] = '{2'b10, 4'b0000, 3'b000, 32'h00003000, 0, 32'h5A5A5A5A, 0, 8, 0, 32'h5A5A5A5A, 0, 10, 1, 32'h00003000, 0, 4'b0000, 0};
    vecs[13] = '{2'b10, 4'b0000, 3'b000, 32'h00003000, 0, 32'h5A5A5A5A, 0, 9, 0, 0, 1, 10, 1, 32'h00003000, 0, 4'b0000, 0};
    vecs[14] = '{2'b01, 4'b0110, 3'b000, 32'h00004002, 32'h0000FFFF, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 0};
    vecs[15] = '{2'b10, 4'b0000, 3'b100, 32'h00005001, 0, 32'h12345678, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 0};
    vecs[16] = '{2'b10, 4'b0000, 3'b111, 32'h00006000, 0, 32'hCAFEF00D, 0, 1, 0, 32'hCAFEF00D, 0, 3, 1, 32'h00006000, 0, 4'b0000, 0};
    vecs[17] = '{2'b01, 4'b1111, 3'b000, 32'h00007000, 32'h89ABCDEF, 0, 0, 2, 0, 0, 0, 4, 1, 32'h00007000, 32'h89ABCDEF, 4'b1111, 1};
    vecs[18] = '{2'b10, 4'b0000, 3'b100, 32'h00008002, 0, 32'h92340000, 0, 1, 0, 32'h00009234, 0, 3, 1, 32'h00008000, 0, 4'b0000, 0};

    rst_n = 1'b0; in_valid = 1'b0; MemRW = 2'b00; wmask = 4'b0000; memExt = 3'b000;
    addr = 32'd0; wdata = 32'd0; out_ready = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
    #1;
    checkResetOutputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("afterReset");

    for (int i = 0; i < 19; i++) begin
      runOp(vecs[i], o);
      checkObs($sformatf("vec%0d", i), vecs[i], o);
    end

    // Reset while waiting for the response; a late response must be ignored.
    @(negedge clk);
    in_valid = 1'b1; MemRW = 2'b10; wmask = 4'b0000; memExt = 3'b000; addr = 32'h80000010;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstWait.reqValid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("rstWait");
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hFEEDFACE;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("lateResp.out_valid", 32'(out_valid), 32'd0);
    check("lateResp.in_ready", 32'(in_ready), 32'd1);
    check("lateResp.rdata", rdata, 32'd0);

    // Reset while the request is still pending drops mem_req_valid at once.
    in_valid = 1'b1; MemRW = 2'b01; wmask = 4'b1111; addr = 32'h00000040; wdata = 32'h01020304;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstReq.reqValid", 32'(mem_req_valid), 32'd1);
    check("rstReq.reqAddr", mem_req_addr, 32'h00000040);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("rstReq");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      v = '{default: 0};
      v.rw = (r <= 4) ? 2'b10 : (r <= 7) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
      case ($urandom_range(0, 4))
        0: v.mask = 4'b0001;
        1: v.mask = 4'b0011;
        2: v.mask = 4'b1111;
        3: v.mask = 4'b0000;
        default: v.mask = 4'($urandom);
      endcase
      v.ext      = 3'($urandom_range(0, 7));
      v.a        = $urandom;
      v.wd       = $urandom;
      v.resp     = $urandom;
      v.readyLat = $urandom_range(0, 3);
      v.respLat  = $urandom_range(0, 10);
      v.outLat   = $urandom_range(0, 2);
      refModel(v);
      runOp(v, o);
      checkObs($sformatf("rand%0d", i), v, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
